// File: rtl/scan_rw_pkg.sv
// Shared types and constants for the scan read/write controller.
// Holds the FSM state encoding, the static_err bit positions and the
// data pattern returned by a read that is aborted by the WAIT timeout.
package scan_rw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Bit positions inside static_err
  localparam int ERR_OVF = 0;
  localparam int ERR_TMO = 1;

  // An aborted read returns this bit replicated across the data width
  localparam bit TMO_FILL_BIT = 1'b1;

endpackage

// File: rtl/scan_rw_ctrl_if.sv
// Bus bundle for scan_rw_ctrl: the static request side and the scan
// command side. The master modport is the controller's view (it issues
// scan commands); slave is the view of the requester/target environment.
interface scan_rw_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);

  logic              id_valid;
  logic              static_wen;
  logic              static_ren;
  logic [ADDR_W-1:0] static_addr;
  logic [DATA_W-1:0] static_wdata;
  logic              static_ready;
  logic [DATA_W-1:0] static_rdata;
  logic              rd_valid;
  logic [1:0]        static_err;
  logic              err_clr;
  logic              scan_wen;
  logic              scan_ren;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_wdata;
  logic [DATA_W-1:0] scan_rdata;
  logic              scan_ready;

  modport master (
    input  id_valid, static_wen, static_ren, static_addr, static_wdata,
    input  err_clr, scan_rdata, scan_ready,
    output static_ready, static_rdata, rd_valid, static_err,
    output scan_wen, scan_ren, scan_addr, scan_wdata
  );

  modport slave (
    output id_valid, static_wen, static_ren, static_addr, static_wdata,
    output err_clr, scan_rdata, scan_ready,
    input  static_ready, static_rdata, rd_valid, static_err,
    input  scan_wen, scan_ren, scan_addr, scan_wdata
  );

endinterface

// File: rtl/scan_rw_fifo.sv
// Synchronous request FIFO with full/empty flags. DEPTH must be a power
// of two so the pointers wrap naturally. A push and a pop in the same
// cycle are allowed even when full; the caller gates illegal pushes/pops.
module scan_rw_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage array: data only, never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scan_rw_ctrl.sv
// Static-to-scan read/write controller. Requests qualified by id_valid are
// queued in scan_rw_fifo and replayed one at a time as single-cycle
// scan_wen/scan_ren commands, each waiting for the target's scan_ready.
// Optional macro SCAN_RW_CTRL_TIMEOUT_EN adds a WAIT-state timeout that
// aborts a stalled command after TIMEOUT_CYC cycles.
module scan_rw_ctrl
  import scan_rw_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  scan_rw_ctrl_if.master bus
);

  localparam int REQ_W = 1 + ADDR_W + DATA_W;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("scan_rw_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  state_t            state;
  logic              is_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [REQ_W-1:0]  fifo_din;
  logic [REQ_W-1:0]  fifo_dout;
  logic              req;
  logic              pop;
  logic              accept;
  logic              overflow;
  logic              done_ok;
  logic              tmo;
  logic              done;
  logic              scan_wen_q;
  logic              scan_ren_q;
  logic [ADDR_W-1:0] scan_addr_q;
  logic [DATA_W-1:0] scan_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rd_valid_q;
  logic              ready_q;
  logic [1:0]        err_q;

  // A write wins over a simultaneous read; read entries carry zero data
  assign req      = bus.id_valid & (bus.static_wen | bus.static_ren);
  assign pop      = (state == ST_IDLE) & ~fifo_empty;
  assign accept   = req & (~fifo_full | pop);
  assign overflow = req & fifo_full & ~pop;
  assign fifo_din = {bus.static_wen, bus.static_addr,
                     bus.static_wen ? bus.static_wdata : {DATA_W{1'b0}}};
  assign done_ok  = (state == ST_WAIT) & bus.scan_ready;
  assign done     = done_ok | tmo;

  scan_rw_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef SCAN_RW_CTRL_TIMEOUT_EN
  localparam int             TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = 1;

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo = (state == ST_WAIT) & ~bus.scan_ready & (tmo_cnt == TMO_LAST);

  // Counts WAIT cycles; cleared in every other state so each command starts at 0
  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TMO_ONE;
  end
`else
  assign tmo = 1'b0;
`endif

  // Command FSM: pop in IDLE, one-cycle strobe in ISSUE, hold in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      is_wr        <= 1'b0;
      scan_wen_q   <= 1'b0;
      scan_ren_q   <= 1'b0;
      scan_addr_q  <= '0;
      scan_wdata_q <= '0;
      rdata_q      <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      scan_wen_q <= 1'b0;
      scan_ren_q <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state        <= ST_ISSUE;
            is_wr        <= fifo_dout[REQ_W-1];
            scan_wen_q   <= fifo_dout[REQ_W-1];
            scan_ren_q   <= ~fifo_dout[REQ_W-1];
            scan_addr_q  <= fifo_dout[DATA_W +: ADDR_W];
            scan_wdata_q <= fifo_dout[DATA_W-1:0];
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (done) begin
            state        <= ST_IDLE;
            scan_addr_q  <= '0;
            scan_wdata_q <= '0;
            if (!is_wr) begin
              rdata_q    <= done_ok ? bus.scan_rdata : {DATA_W{TMO_FILL_BIT}};
              rd_valid_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Ready drops after an accept and rises once nothing is queued or in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      err_q   <= '0;
    end else begin
      if (accept)                                    ready_q <= 1'b0;
      else if (fifo_empty && (state == ST_IDLE || done)) ready_q <= 1'b1;

      if (overflow)         err_q[ERR_OVF] <= 1'b1;
      else if (bus.err_clr) err_q[ERR_OVF] <= 1'b0;

      if (tmo)              err_q[ERR_TMO] <= 1'b1;
      else if (bus.err_clr) err_q[ERR_TMO] <= 1'b0;
    end
  end

  assign bus.scan_wen     = scan_wen_q;
  assign bus.scan_ren     = scan_ren_q;
  assign bus.scan_addr    = scan_addr_q;
  assign bus.scan_wdata   = scan_wdata_q;
  assign bus.static_rdata = rdata_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.static_ready = ready_q;
  assign bus.static_err   = err_q;

endmodule

// File: tb/tb_scan_rw_ctrl.sv
// Directed testbench for scan_rw_ctrl (FIFO_DEPTH=4, TIMEOUT_CYC=8).
// Covers the SCAN_RW_CTRL_TIMEOUT_EN build and the default build.
module tb_scan_rw_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  scan_rw_ctrl_if #(.ADDR_W(14), .DATA_W(32)) bus ();

  scan_rw_ctrl #(
    .ADDR_W      (14),
    .DATA_W      (32),
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Holds one request on the static side for a single cycle
  task automatic drive_req(input logic w, input logic r, input logic [13:0] a, input logic [31:0] d);
    bus.id_valid     = 1'b1;
    bus.static_wen   = w;
    bus.static_ren   = r;
    bus.static_addr  = a;
    bus.static_wdata = d;
    tick();
    bus.id_valid     = 1'b0;
    bus.static_wen   = 1'b0;
    bus.static_ren   = 1'b0;
  endtask

  initial begin
    bus.id_valid     = 1'b0;
    bus.static_wen   = 1'b0;
    bus.static_ren   = 1'b0;
    bus.static_addr  = '0;
    bus.static_wdata = '0;
    bus.err_clr      = 1'b0;
    bus.scan_rdata   = '0;
    bus.scan_ready   = 1'b0;

    // Reset state
    tick(); tick();
    check_eq("rst_ready",    64'(bus.static_ready), 64'd0);
    check_eq("rst_err",      64'(bus.static_err),   64'd0);
    check_eq("rst_rdata",    64'(bus.static_rdata), 64'd0);
    check_eq("rst_rd_valid", 64'(bus.rd_valid),     64'd0);
    check_eq("rst_scan_wen", 64'(bus.scan_wen),     64'd0);
    check_eq("rst_scan_ren", 64'(bus.scan_ren),     64'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Single write: accept at T, strobe at T+2, completion at T+4
    drive_req(1'b1, 1'b0, 14'h0010, 32'hA5A5_0001);      // T+1
    check_eq("wr_t1_wen", 64'(bus.scan_wen), 64'd0);
    tick();                                              // T+2
    check_eq("wr_t2_wen",   64'(bus.scan_wen),     64'd1);
    check_eq("wr_t2_ren",   64'(bus.scan_ren),     64'd0);
    check_eq("wr_t2_addr",  64'(bus.scan_addr),    64'h0010);
    check_eq("wr_t2_wdata", 64'(bus.scan_wdata),   64'hA5A5_0001);
    check_eq("wr_t2_ready", 64'(bus.static_ready), 64'd0);
    tick();                                              // T+3
    check_eq("wr_t3_wen",  64'(bus.scan_wen),  64'd0);
    check_eq("wr_t3_addr", 64'(bus.scan_addr), 64'h0010);
    tick();                                              // T+4
    bus.scan_ready = 1'b1;
    tick();                                              // T+5
    bus.scan_ready = 1'b0;
    check_eq("wr_t5_ready",    64'(bus.static_ready), 64'd1);
    check_eq("wr_t5_rd_valid", 64'(bus.rd_valid),     64'd0);
    check_eq("wr_t5_addr",     64'(bus.scan_addr),    64'd0);
    check_eq("wr_t5_wdata",    64'(bus.scan_wdata),   64'd0);

    // Single read; scan_ready during ISSUE must be ignored
    bus.scan_rdata = 32'hDEAD_BEEF;
    drive_req(1'b0, 1'b1, 14'h3FFF, 32'h1234_5678);      // T+1
    tick();                                              // T+2
    check_eq("rd_t2_ren",   64'(bus.scan_ren),   64'd1);
    check_eq("rd_t2_wen",   64'(bus.scan_wen),   64'd0);
    check_eq("rd_t2_addr",  64'(bus.scan_addr),  64'h3FFF);
    check_eq("rd_t2_wdata", 64'(bus.scan_wdata), 64'd0);
    bus.scan_ready = 1'b1;
    tick();                                              // T+3
    bus.scan_ready = 1'b0;
    tick();                                              // T+4
    check_eq("rd_issue_ready_ignored", 64'(bus.rd_valid),     64'd0);
    check_eq("rd_t4_static_ready",     64'(bus.static_ready), 64'd0);
    check_eq("rd_t4_rdata",            64'(bus.static_rdata), 64'd0);
    bus.scan_ready = 1'b1;
    tick();                                              // T+5
    bus.scan_ready = 1'b0;
    check_eq("rd_done_valid", 64'(bus.rd_valid),     64'd1);
    check_eq("rd_done_rdata", 64'(bus.static_rdata), 64'hDEAD_BEEF);
    check_eq("rd_done_ready", 64'(bus.static_ready), 64'd1);
    tick();
    check_eq("rd_valid_pulse", 64'(bus.rd_valid),     64'd0);
    check_eq("rd_rdata_hold",  64'(bus.static_rdata), 64'hDEAD_BEEF);

    // scan_ready while idle does nothing
    bus.scan_ready = 1'b1;
    tick();
    bus.scan_ready = 1'b0;
    check_eq("idle_ready_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("idle_ready_wen",   64'(bus.scan_wen), 64'd0);

    // wen+ren -> write only; queued read issues two cycles after completion
    bus.id_valid = 1'b1; bus.static_wen = 1'b1; bus.static_ren = 1'b1;
    bus.static_addr = 14'h0002; bus.static_wdata = 32'hCAFE_0002;
    tick();                                              // T+1
    bus.static_wen = 1'b0; bus.static_addr = 14'h0005; bus.static_wdata = 32'h0;
    tick();                                              // T+2
    bus.id_valid = 1'b0; bus.static_ren = 1'b0;
    check_eq("both_wen",   64'(bus.scan_wen),   64'd1);
    check_eq("both_ren",   64'(bus.scan_ren),   64'd0);
    check_eq("both_addr",  64'(bus.scan_addr),  64'h0002);
    check_eq("both_wdata", 64'(bus.scan_wdata), 64'hCAFE_0002);
    tick();                                              // T+3 (WAIT)
    bus.scan_ready = 1'b1; bus.scan_rdata = 32'h0BAD_F00D;
    tick();                                              // T+4
    bus.scan_ready = 1'b0;
    check_eq("wrdone_rd_valid", 64'(bus.rd_valid),     64'd0);
    check_eq("wrdone_rdata",    64'(bus.static_rdata), 64'hDEAD_BEEF);
    check_eq("wrdone_ren_r1",   64'(bus.scan_ren),     64'd0);
    check_eq("wrdone_ready",    64'(bus.static_ready), 64'd0);
    tick();                                              // T+5 = R+2
    check_eq("next_ren_r2",  64'(bus.scan_ren),  64'd1);
    check_eq("next_addr_r2", 64'(bus.scan_addr), 64'h0005);
    tick();                                              // WAIT
    bus.scan_ready = 1'b1;
    tick();
    bus.scan_ready = 1'b0;
    check_eq("q_rd_valid", 64'(bus.rd_valid),     64'd1);
    check_eq("q_rd_rdata", 64'(bus.static_rdata), 64'h0BAD_F00D);

`ifdef SCAN_RW_CTRL_TIMEOUT_EN
    // Stalled read aborts after 8 WAIT cycles
    drive_req(1'b0, 1'b1, 14'h0100, 32'h0);              // T+1
    repeat (9) tick();                                   // T+10
    check_eq("tmo_early_valid", 64'(bus.rd_valid),   64'd0);
    check_eq("tmo_early_err",   64'(bus.static_err), 64'd0);
    tick();                                              // T+11
    check_eq("tmo_valid", 64'(bus.rd_valid),     64'd1);
    check_eq("tmo_rdata", 64'(bus.static_rdata), 64'hFFFF_FFFF);
    check_eq("tmo_err",   64'(bus.static_err),   64'd2);
    check_eq("tmo_ready", 64'(bus.static_ready), 64'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check_eq("tmo_err_clr", 64'(bus.static_err), 64'd0);
`else
    // Without the timeout a stalled read waits indefinitely
    drive_req(1'b0, 1'b1, 14'h0100, 32'h0);
    repeat (20) tick();
    check_eq("stall_valid", 64'(bus.rd_valid),     64'd0);
    check_eq("stall_err",   64'(bus.static_err),   64'd0);
    check_eq("stall_ready", 64'(bus.static_ready), 64'd0);
    bus.scan_ready = 1'b1; bus.scan_rdata = 32'h1111_2222;
    tick();
    bus.scan_ready = 1'b0;
    check_eq("stall_done_valid", 64'(bus.rd_valid),     64'd1);
    check_eq("stall_done_rdata", 64'(bus.static_rdata), 64'h1111_2222);
`endif

    // Overflow: one read stalled in WAIT, then 5 back-to-back writes
    drive_req(1'b0, 1'b1, 14'h0200, 32'h0);              // T0+1
    tick(); tick();                                      // T0+3 (WAIT)
    for (int i = 0; i < 5; i++) begin
      bus.id_valid = 1'b1; bus.static_wen = 1'b1;
      bus.static_addr = 14'h0300 + 14'(i); bus.static_wdata = 32'h1000 + 32'(i);
      tick();
      if (i == 3) check_eq("ovf_4th_no_err", 64'(bus.static_err), 64'd0);
    end                                                  // T0+8
    check_eq("ovf_err",   64'(bus.static_err),   64'd1);
    check_eq("ovf_ready", 64'(bus.static_ready), 64'd0);
    bus.static_addr = 14'h03AA; bus.err_clr = 1'b1;      // still full: new error beats clear
    tick();                                              // T0+9
    bus.id_valid = 1'b0; bus.static_wen = 1'b0;
    check_eq("ovf_err_wins", 64'(bus.static_err), 64'd1);
    tick();                                              // T0+10
    bus.err_clr = 1'b0;
    check_eq("ovf_err_clr", 64'(bus.static_err), 64'd0);
    bus.scan_ready = 1'b1; bus.scan_rdata = 32'h55AA_55AA;
    tick();                                              // T0+11: IDLE, popping a full FIFO
    bus.scan_ready = 1'b0;
    check_eq("full_rd_valid", 64'(bus.rd_valid),     64'd1);
    check_eq("full_rd_rdata", 64'(bus.static_rdata), 64'h55AA_55AA);
    bus.id_valid = 1'b1; bus.static_wen = 1'b1;
    bus.static_addr = 14'h03FF; bus.static_wdata = 32'h0;
    tick();                                              // T0+12
    bus.id_valid = 1'b0; bus.static_wen = 1'b0;
    check_eq("pop_push_no_ovf", 64'(bus.static_err), 64'd0);
    check_eq("fifo_head_wen",   64'(bus.scan_wen),   64'd1);
    check_eq("fifo_head_addr",  64'(bus.scan_addr),  64'h0300);
    check_eq("fifo_head_wdata", 64'(bus.scan_wdata), 64'h1000);
    tick();                                              // T0+13 (WAIT)

    // Reset during WAIT abandons everything
    rst = 1'b1;
    tick();
    check_eq("wrst_wen",      64'(bus.scan_wen),     64'd0);
    check_eq("wrst_ren",      64'(bus.scan_ren),     64'd0);
    check_eq("wrst_addr",     64'(bus.scan_addr),    64'd0);
    check_eq("wrst_wdata",    64'(bus.scan_wdata),   64'd0);
    check_eq("wrst_ready",    64'(bus.static_ready), 64'd0);
    check_eq("wrst_rdata",    64'(bus.static_rdata), 64'd0);
    check_eq("wrst_rd_valid", 64'(bus.rd_valid),     64'd0);
    check_eq("wrst_err",      64'(bus.static_err),   64'd0);
    rst = 1'b0;
    bus.scan_ready = 1'b1;
    tick();
    bus.scan_ready = 1'b0;
    check_eq("late_ready_valid", 64'(bus.rd_valid), 64'd0);
    tick();
    check_eq("late_ready_valid2", 64'(bus.rd_valid), 64'd0);
    tick();
    check_eq("flushed_wen", 64'(bus.scan_wen), 64'd0);
    check_eq("flushed_ren", 64'(bus.scan_ren), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
